// File: rtl/imem_axi_burst_reader_if.sv
// Request, AXI4 read-address/read-data and instruction-memory stream signals
// of imem_axi_burst_reader, bundled so that one modport serves the engine.
interface imem_axi_burst_reader_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int LEN_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_beats;

    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;

    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic              m_axi_rlast;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              done;
    logic              err;

    modport master (
        input  req_valid, req_addr, req_beats,
        output req_ready,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        output m_axi_rready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output done, err
    );

    modport slave (
        output req_valid, req_addr, req_beats,
        input  req_ready,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        input  m_axi_rready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  done, err
    );
endinterface

// File: rtl/imem_axi_burst_reader.sv
// Splits one (address, beat count) request into AXI4 INCR read bursts that stay
// inside 4 KB pages. Optional rlast checker: define IMEM_AXI_RLAST_CHECK_EN.
module imem_axi_burst_reader #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 512,
    parameter int MAX_BURST_BEATS = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_W           = 16
) (
    input logic                     ap_clk,
    input logic                     ap_rst,
    imem_axi_burst_reader_if.master bus
);
    localparam int BPB   = DATA_W / 8;
    localparam int OFF_W = $clog2(BPB);
    localparam int CW    = (LEN_W > 13) ? LEN_W : 13;
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  ar_rem;
    logic [LEN_W-1:0]  r_rem;
    logic [OW-1:0]     outstanding;

    logic [CW-1:0]     page_beats;
    logic [CW-1:0]     len;
    logic              busy;
    logic              req_ready;
    logic              ar_valid;
    logic              rready;
    logic              req_hs;
    logic              ar_hs;
    logic              r_hs;
    logic              r_last_hs;
    logic              unused_addr_lsb;

    assign busy      = (state == S_BUSY);
    assign req_ready = (state == S_IDLE) && !ap_rst;
    assign ar_valid  = busy && (ar_rem != '0) && (outstanding < OW'(MAX_OUTSTANDING));
    assign rready    = bus.out_ready && busy;

    assign req_hs    = bus.req_valid && req_ready;
    assign ar_hs     = ar_valid && bus.m_axi_arready;
    assign r_hs      = bus.m_axi_rvalid && rready;
    assign r_last_hs = r_hs && bus.m_axi_rlast && (outstanding != '0);

    // Burst length is the smallest of remaining beats, the burst cap and the
    // beats left before the next 4 KB page.
    always_comb begin
        page_beats = CW'((13'd4096 - {1'b0, addr[11:0]}) >> OFF_W);
        len        = CW'(ar_rem);
        if (len > CW'(MAX_BURST_BEATS)) len = CW'(MAX_BURST_BEATS);
        if (len > page_beats)           len = page_beats;
    end

    assign bus.req_ready     = req_ready;
    assign bus.m_axi_arvalid = ar_valid;
    assign bus.m_axi_araddr  = addr;
    assign bus.m_axi_arlen   = ar_valid ? 8'(len - CW'(1)) : 8'd0;
    assign bus.m_axi_rready  = rready;
    assign bus.out_valid     = bus.m_axi_rvalid && busy;
    assign bus.out_data      = bus.m_axi_rdata;
    assign bus.out_last      = (r_rem == LEN_W'(1));
    assign bus.done          = (state == S_DONE);

    // Sub-beat address bits are discarded on purpose.
    assign unused_addr_lsb = &{1'b0, bus.req_addr[OFF_W-1:0]};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= S_IDLE;
        else        state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (req_hs) state_nx = (bus.req_beats == '0) ? S_DONE : S_BUSY;
            S_BUSY: if (r_hs && (r_rem == LEN_W'(1))) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            addr        <= '0;
            ar_rem      <= '0;
            r_rem       <= '0;
            outstanding <= '0;
        end else begin
            if (req_hs) begin
                addr   <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                ar_rem <= bus.req_beats;
                r_rem  <= bus.req_beats;
            end else begin
                if (ar_hs) begin
                    addr   <= addr + (ADDR_W'(len) << OFF_W);
                    ar_rem <= ar_rem - LEN_W'(len);
                end
                if (r_hs) r_rem <= r_rem - LEN_W'(1);
            end
            unique case ({ar_hs, r_last_hs})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef IMEM_AXI_RLAST_CHECK_EN
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [7:0]    len_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [7:0]    beat_cnt;
    logic          exp_last;
    logic          err_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // The FIFO holds exactly one arlen per outstanding burst, in issue order.
    assign exp_last = (beat_cnt == len_fifo[rd_ptr]);

    // NOTE: storage arrays carry no reset; the pointers define which entries
    // are valid, and leaving the RAM unreset lets it map onto LUTRAM/BRAM.
    always_ff @(posedge ap_clk) begin
        if (ar_hs) len_fifo[wr_ptr] <= bus.m_axi_arlen;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (ar_hs) wr_ptr <= ptr_inc(wr_ptr);
            if (req_hs) begin
                err_q <= 1'b0;
            end else if (r_hs && ((outstanding == '0) || (bus.m_axi_rlast != exp_last))) begin
                err_q <= 1'b1;
            end
            if (r_hs && (outstanding != '0)) begin
                if (bus.m_axi_rlast) begin
                    rd_ptr   <= ptr_inc(rd_ptr);
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_axi_burst_reader.sv
// Directed bench for imem_axi_burst_reader: table of burst-splitting vectors
// driven against a small AXI memory model, plus hand-written corner sequences.
module tb_imem_axi_burst_reader;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int LEN_W  = 16;
    localparam int BPB    = 64;
`ifdef IMEM_AXI_RLAST_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    imem_axi_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    imem_axi_burst_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST_BEATS(16),
        .MAX_OUTSTANDING(4), .LEN_W(LEN_W)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0]      addr;
        int               beats;
        bit               bp;
        int               n_ar;
        logic [2:0][63:0] ar_addr;
        logic [2:0][7:0]  ar_len;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got low word 0x%0h, expected 0x%0h", name, act[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DATA_W-1:0] beat_data(input logic [63:0] a);
        return {8{a}};
    endfunction

    function automatic vec_t mk(input logic [63:0] a, input int b, input bit bp, input int n,
                                input logic [63:0] a0, input int l0,
                                input logic [63:0] a1, input int l1,
                                input logic [63:0] a2, input int l2);
        vec_t v;
        v.addr = a; v.beats = b; v.bp = bp; v.n_ar = n;
        v.ar_addr[0] = a0; v.ar_len[0] = 8'(l0);
        v.ar_addr[1] = a1; v.ar_len[1] = 8'(l1);
        v.ar_addr[2] = a2; v.ar_len[2] = 8'(l2);
        return v;
    endfunction

    task automatic do_req(input logic [63:0] a, input int b);
        @(negedge ap_clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_beats = LEN_W'(b);
        #1 check("req_ready idle", bus.req_ready, 1'b1);
        @(posedge ap_clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, bus.req_ready, 1'b0);
        check({tag, " arvalid"},   bus.m_axi_arvalid, 1'b0);
        check({tag, " araddr"},    bus.m_axi_araddr, 64'h0);
        check({tag, " arlen"},     bus.m_axi_arlen, 8'h0);
        check({tag, " rready"},    bus.m_axi_rready, 1'b0);
        check({tag, " out_valid"}, bus.out_valid, 1'b0);
        check({tag, " out_last"},  bus.out_last, 1'b0);
        check({tag, " done"},      bus.done, 1'b0);
        check({tag, " err"},       bus.err, 1'b0);
    endtask

    // One request against the memory model; every AR and output beat is compared.
    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] bq_addr[$];
        int          bq_len[$];
        logic [63:0] base = v.addr & ~64'h3F;
        logic [63:0] r_addr = '0;
        logic [63:0] prev_addr = '0;
        logic [7:0]  prev_len = '0;
        int r_len = 0, r_beat = 0, ar_cnt = 0, out_cnt = 0;
        int last_hs_cyc = -10, done_cyc = -1;
        bit r_act = 0, fin = 0, prev_stall = 0;
        bit track_ok = 1, stable_ok = 1, last_ok = 1;

        do_req(v.addr, v.beats);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge ap_clk);
            if (!r_act && bq_addr.size() > 0) begin
                r_addr = bq_addr.pop_front();
                r_len  = bq_len.pop_front();
                r_beat = 0;
                r_act  = 1;
            end
            bus.m_axi_rvalid  = r_act;
            bus.m_axi_rdata   = r_act ? beat_data(r_addr + 64'(r_beat) * BPB) : '0;
            bus.m_axi_rlast   = r_act && (r_beat == r_len);
            bus.out_ready     = v.bp ? ($urandom_range(0, 99) >= 30) : 1'b1;
            bus.m_axi_arready = v.bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (bus.done) begin
                fin = 1;
                done_cyc = cyc;
            end else begin
                if (bus.m_axi_rready !== bus.out_ready) track_ok = 0;
                if (bus.out_valid !== bus.m_axi_rvalid) track_ok = 0;
            end
            if (prev_stall && (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_araddr !== prev_addr ||
                               bus.m_axi_arlen !== prev_len)) stable_ok = 0;
            prev_stall = bus.m_axi_arvalid && !bus.m_axi_arready;
            prev_addr  = bus.m_axi_araddr;
            prev_len   = bus.m_axi_arlen;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                if (ar_cnt < v.n_ar) begin
                    check($sformatf("v%0d ar%0d addr", idx, ar_cnt), bus.m_axi_araddr, v.ar_addr[ar_cnt]);
                    check($sformatf("v%0d ar%0d len", idx, ar_cnt), bus.m_axi_arlen, v.ar_len[ar_cnt]);
                end
                ar_cnt++;
                bq_addr.push_back(bus.m_axi_araddr);
                bq_len.push_back(int'(bus.m_axi_arlen));
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                check_data($sformatf("v%0d beat%0d data", idx, out_cnt), bus.out_data,
                           beat_data(base + 64'(out_cnt) * BPB));
                if (bus.out_last !== (out_cnt == v.beats - 1)) last_ok = 0;
                out_cnt++;
                last_hs_cyc = cyc;
                r_beat++;
                if (r_beat > r_len) r_act = 0;
            end
        end
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        check($sformatf("v%0d done seen", idx), fin, 1'b1);
        check($sformatf("v%0d done latency", idx), 64'(done_cyc - last_hs_cyc), 64'd1);
        check($sformatf("v%0d ar count", idx), 64'(ar_cnt), 64'(v.n_ar));
        check($sformatf("v%0d beat count", idx), 64'(out_cnt), 64'(v.beats));
        check($sformatf("v%0d out_last placement", idx), last_ok, 1'b1);
        check($sformatf("v%0d rready/out_valid track", idx), track_ok, 1'b1);
        check($sformatf("v%0d ar held while stalled", idx), stable_ok, 1'b1);
        check($sformatf("v%0d err", idx), bus.err, 1'b0);
        @(negedge ap_clk);
        #1;
        check($sformatf("v%0d done one cycle", idx), bus.done, 1'b0);
        check($sformatf("v%0d back to idle", idx), bus.req_ready, 1'b1);
    endtask

    vec_t vecs[8];

    initial begin
        int  ar_cnt;
        bit  ok;

        vecs[0] = mk(64'h1000, 40, 0, 3, 64'h1000, 15, 64'h1400, 15, 64'h1800, 7);
        vecs[1] = mk(64'h0FC0,  4, 0, 2, 64'h0FC0,  0, 64'h1000,  2, 64'h0,    0);
        vecs[2] = mk(64'h2003,  3, 0, 1, 64'h2000,  2, 64'h0,     0, 64'h0,    0);
        vecs[3] = mk(64'h0E00, 20, 0, 2, 64'h0E00,  7, 64'h1000, 11, 64'h0,    0);
        vecs[4] = mk(64'h3000, 16, 0, 1, 64'h3000, 15, 64'h0,     0, 64'h0,    0);
        vecs[5] = mk(64'h4C40, 17, 0, 2, 64'h4C40, 14, 64'h5000,  1, 64'h0,    0);
        vecs[6] = mk(64'h7FC0,  1, 0, 1, 64'h7FC0,  0, 64'h0,     0, 64'h0,    0);
        vecs[7] = mk(64'h1000, 40, 1, 3, 64'h1000, 15, 64'h1400, 15, 64'h1800, 7);

        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.req_beats     = '0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rlast   = 1'b0;
        bus.out_ready     = 1'b0;

        repeat (3) @(negedge ap_clk);
        #1 check_reset_outputs("reset");
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1 check("req_ready after release", bus.req_ready, 1'b1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Zero-length request: no AR, done in the cycle following acceptance.
        bus.m_axi_arready = 1'b1;
        do_req(64'h8000, 0);
        @(negedge ap_clk);
        #1;
        check("zero done", bus.done, 1'b1);
        check("zero no ar", bus.m_axi_arvalid, 1'b0);
        @(negedge ap_clk);
        #1;
        check("zero done drops", bus.done, 1'b0);
        check("zero idle", bus.req_ready, 1'b1);

        // Outstanding limit with R withheld, then one burst frees a slot.
        bus.out_ready = 1'b1;
        do_req(64'h10000, 100);
        ar_cnt = 0;
        repeat (8) begin
            @(negedge ap_clk);
            #1 if (bus.m_axi_arvalid && bus.m_axi_arready) ar_cnt++;
        end
        check("ostd ar count", 64'(ar_cnt), 64'd4);
        check("ostd arvalid low", bus.m_axi_arvalid, 1'b0);
        ok = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge ap_clk);
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = beat_data(64'h10000 + 64'(i) * BPB);
            bus.m_axi_rlast  = (i == 15);
            #1 if (bus.m_axi_arvalid !== 1'b0 || bus.m_axi_rready !== 1'b1) ok = 0;
        end
        check("ostd no ar before rlast", ok, 1'b1);
        @(negedge ap_clk);
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        #1;
        check("ostd 5th arvalid", bus.m_axi_arvalid, 1'b1);
        check("ostd 5th araddr", bus.m_axi_araddr, 64'h11000);
        check("ostd 5th arlen", bus.m_axi_arlen, 8'd15);
        @(negedge ap_clk);
        #1 check("ostd full again", bus.m_axi_arvalid, 1'b0);

        // Reset in the middle of the transfer drops everything at once.
        @(negedge ap_clk);
        ap_rst = 1'b1;
        #1 check_reset_outputs("mid reset");
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1 check("idle after mid reset", bus.req_ready, 1'b1);

        // Early rlast: arlen 3 burst terminated on its second beat.
        do_req(64'h0, 4);
        @(negedge ap_clk);
        #1 check("rlast test arlen", bus.m_axi_arlen, 8'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = beat_data(64'(i) * BPB);
            bus.m_axi_rlast  = (i == 1) || (i == 3);
            #1;
            if (i == 2) check("err after early rlast", bus.err, ERR_EXP);
            check_data($sformatf("rlast test beat%0d data", i), bus.out_data, beat_data(64'(i) * BPB));
        end
        @(negedge ap_clk);
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        #1;
        check("rlast test done", bus.done, 1'b1);
        check("err sticky at done", bus.err, ERR_EXP);
        @(negedge ap_clk);
        #1 check("err sticky in idle", bus.err, ERR_EXP);
        do_req(64'h40, 0);
        check("err cleared on accept", bus.err, 1'b0);
        @(negedge ap_clk);
        #1 check("err test final done", bus.done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
